// File: rtl/vga_pkg.sv
// Shared timing constants, colour type and small helpers for the VGA scan-out path.
package vga_pkg;

    // 640x480@60 default timing
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    // Derived totals and sync windows (inclusive bounds)
    localparam int H_TOTAL_DEF    = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF    = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
    localparam int H_SYNC_START   = H_VISIBLE_DEF + H_FRONT_DEF;
    localparam int H_SYNC_END     = H_SYNC_START + H_SYNC_DEF - 1;
    localparam int V_SYNC_START   = V_VISIBLE_DEF + V_FRONT_DEF;
    localparam int V_SYNC_END     = V_SYNC_START + V_SYNC_DEF - 1;

    // Width of the raster counters; covers totals up to 1023
    localparam int CNT_W = 10;

    // 6-bit RRGGBB colour
    typedef logic [5:0] rgb_t;

    localparam rgb_t RGB_BLACK = 6'b00_00_00;
    localparam rgb_t RGB_GOLD  = 6'b11_10_00;
    localparam rgb_t RGB_RED   = 6'b11_00_00;

    // True when v lies in the closed interval [lo, hi]
    function automatic logic in_window(input logic [CNT_W-1:0] v,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_scanout_scan_counter.sv
// Horizontal/vertical raster counter pair with wrap, synchronous reset and
// an end-of-frame strobe that is high on the last pixel of the frame.
module scan_counter
    import vga_pkg::*;
#(
    parameter int H_TOTAL = H_TOTAL_DEF,
    parameter int V_TOTAL = V_TOTAL_DEF
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] h_cnt_o,
    output logic [CNT_W-1:0] v_cnt_o,
    output logic             eof_o
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             h_wrap;
    logic             v_wrap;

    // Next-count logic: h always advances, v advances only when h wraps
    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        v_wrap  = (v_cnt_q == V_LAST);
        h_cnt_d = h_wrap ? '0 : h_cnt_q + CNT_W'(1);
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + CNT_W'(1);
        end
    end

    // Counter flops; reset restarts the raster at the top-left pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o = h_cnt_q;
    assign v_cnt_o = v_cnt_q;
    assign eof_o   = h_wrap && v_wrap;

endmodule

// File: rtl/vga_scanout.sv
// VGA raster timing source and final pixel stage.
// x/y/active/line_start/frame_start come straight off the counters so that
// combinational overlays see the current pixel; colour and both syncs share
// one register stage so they remain aligned at the pins.
// Optional macro VGA_SCANOUT_FRAME_COUNT_EN enables the 8-bit frame counter;
// without it frame_count is tied to 0.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       bg_rgb,
    input  logic             ov_draw,
    input  logic [5:0]       ov_rgb,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             active,
    output logic             line_start,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync,
    output logic [5:0]       rgb_out,
    output logic [7:0]       frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             eof;

    scan_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_scan_counter (
        .clk     (clk),
        .reset   (reset),
        .h_cnt_o (h_cnt),
        .v_cnt_o (v_cnt),
        .eof_o   (eof)
    );

    // Scan coordinates are presented unregistered to the overlay generators
    assign x = h_cnt;
    assign y = v_cnt;

    logic hsync_d, vsync_d;
    logic hsync_q, vsync_q;
    rgb_t rgb_d,   rgb_q;

    // Position decodes and pixel select for the current x/y
    always_comb begin
        active      = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
        line_start  = !reset && (h_cnt == '0);
        frame_start = line_start && (v_cnt == '0);
        hsync_d     = !in_window(h_cnt, HS_START, HS_END);
        vsync_d     = !in_window(v_cnt, VS_START, VS_END);
        rgb_d       = RGB_BLACK;
        if (active) begin
            rgb_d = ov_draw ? ov_rgb : bg_rgb;
        end
    end

    // Single output stage shared by colour and syncs
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= RGB_BLACK;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
        end
    end

    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
    assign rgb_out = rgb_q;

`ifdef VGA_SCANOUT_FRAME_COUNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // Advance on the edge where both counters wrap to the frame origin
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (eof) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // Frame counter flops, wrapping naturally 255 -> 0
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_count = frame_cnt_q;
`else
    logic unused_eof;
    assign unused_eof  = eof;
    assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: a full-size instance for line timing,
// pixel mux and mid-frame reset, and a shrunken-timing instance for frame
// timing and frame counter wrap within a short run.
module tb_vga_scanout;

`ifdef VGA_SCANOUT_FRAME_COUNT_EN
    localparam int FC_EN = 1;
`else
    localparam int FC_EN = 0;
`endif

    localparam int R  = 3;    // first cycle with reset released
    localparam int SF = 176;  // small-instance frame length (16 x 11)

    typedef enum int {S_X, S_Y, S_ACT, S_LS, S_FS, S_HS, S_VS, S_RGB, S_FC,
                      S_HSW, S_HSP, S_VSW, S_ACTL, S_LSF, S_FSP} sel_e;
    typedef struct {
        int   cyc;
        sel_e sel;
        int   exp;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_m, rst_s, ov_en;
    logic [5:0] bg_rgb = 6'b000011;
    logic [5:0] ov_rgb = 6'b110110;

    logic [9:0] x_m, y_m, x_s, y_s;
    logic       act_m, ls_m, fs_m, hs_m, vs_m;
    logic       act_s, ls_s, fs_s, hs_s, vs_s;
    logic [5:0] rgb_m, rgb_s;
    logic [7:0] fc_m, fc_s;
    logic       ov_draw_m;
    logic       ov_draw_s = 1'b1;

    // Overlay generator for the full-size instance
    assign ov_draw_m = ov_en && (y_m == 10'd50) && ((x_m == 10'd100) || (x_m == 10'd700));

    vga_scanout dut (
        .clk(clk), .reset(rst_m), .bg_rgb(bg_rgb), .ov_draw(ov_draw_m), .ov_rgb(ov_rgb),
        .x(x_m), .y(y_m), .active(act_m), .line_start(ls_m), .frame_start(fs_m),
        .hsync(hs_m), .vsync(vs_m), .rgb_out(rgb_m), .frame_count(fc_m)
    );

    vga_scanout #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) dut_s (
        .clk(clk), .reset(rst_s), .bg_rgb(bg_rgb), .ov_draw(ov_draw_s), .ov_rgb(ov_rgb),
        .x(x_s), .y(y_s), .active(act_s), .line_start(ls_s), .frame_start(fs_s),
        .hsync(hs_s), .vsync(vs_s), .rgb_out(rgb_s), .frame_count(fc_s)
    );

    exp_t q_m[$];
    exp_t q_s[$];
    int checks = 0;
    int passes = 0;

    // Measurement state per instance (0 = full size, 1 = small)
    int hs_run[2], hs_width[2], hs_fall[2], hs_period[2];
    int vs_run[2], vs_width[2];
    int act_cnt[2], act_line[2], ls_cnt[2], ls_frame[2], fs_last[2], fs_period[2];
    bit hs_prev[2], vs_prev[2];

    task automatic push_m(input int c, input sel_e s, input int v);
        q_m.push_back('{cyc: c, sel: s, exp: v});
    endtask

    task automatic push_s(input int c, input sel_e s, input int v);
        q_s.push_back('{cyc: c, sel: s, exp: v});
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic update(input int i, input logic hs, input logic vs, input logic act,
                          input logic ls, input logic fs);
        if (!hs) begin
            if (hs_prev[i]) begin
                if (hs_fall[i] > 0) hs_period[i] = cyc - hs_fall[i];
                hs_fall[i] = cyc;
                hs_run[i]  = 0;
            end
            hs_run[i]++;
        end else if (!hs_prev[i]) begin
            hs_width[i] = hs_run[i];
        end
        hs_prev[i] = hs;
        if (!vs) begin
            if (vs_prev[i]) vs_run[i] = 0;
            vs_run[i]++;
        end else if (!vs_prev[i]) begin
            vs_width[i] = vs_run[i];
        end
        vs_prev[i] = vs;
        if (fs) begin
            if (fs_last[i] > 0) fs_period[i] = cyc - fs_last[i];
            fs_last[i]  = cyc;
            ls_frame[i] = ls_cnt[i];
            ls_cnt[i]   = 0;
        end
        if (ls) begin
            act_line[i] = act_cnt[i];
            act_cnt[i]  = 0;
            ls_cnt[i]++;
        end
        if (act) act_cnt[i]++;
    endtask

    function automatic int obs(input int i, input sel_e s);
        case (s)
            S_X:    return (i == 0) ? int'(x_m)   : int'(x_s);
            S_Y:    return (i == 0) ? int'(y_m)   : int'(y_s);
            S_ACT:  return (i == 0) ? int'(act_m) : int'(act_s);
            S_LS:   return (i == 0) ? int'(ls_m)  : int'(ls_s);
            S_FS:   return (i == 0) ? int'(fs_m)  : int'(fs_s);
            S_HS:   return (i == 0) ? int'(hs_m)  : int'(hs_s);
            S_VS:   return (i == 0) ? int'(vs_m)  : int'(vs_s);
            S_RGB:  return (i == 0) ? int'(rgb_m) : int'(rgb_s);
            S_FC:   return (i == 0) ? int'(fc_m)  : int'(fc_s);
            S_HSW:  return hs_width[i];
            S_HSP:  return hs_period[i];
            S_VSW:  return vs_width[i];
            S_ACTL: return act_line[i];
            S_LSF:  return ls_frame[i];
            S_FSP:  return fs_period[i];
            default: return -1;
        endcase
    endfunction

    task automatic compare(input int i, input exp_t e);
        int got;
        string inst;
        inst = (i == 0) ? "full" : "small";
        got  = obs(i, e.sel);
        checks++;
        if (e.cyc != cyc) begin
            $display("FAIL %s.%s: expected at cycle %0d, reached at cycle %0d (required %0d)",
                     inst, e.sel.name(), e.cyc, cyc, e.exp);
        end else if (got == e.exp) begin
            passes++;
            $display("ok   %s.%s cycle %0d = %0d", inst, e.sel.name(), cyc, got);
        end else begin
            $display("FAIL %s.%s cycle %0d: got %0d, required %0d",
                     inst, e.sel.name(), cyc, got, e.exp);
        end
    endtask

    // Monitor: sample on the falling edge, update measurements, drain due entries
    initial begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            hs_run[i] = 0; hs_width[i] = 0; hs_fall[i] = 0; hs_period[i] = 0;
            vs_run[i] = 0; vs_width[i] = 0; act_cnt[i] = 0; act_line[i] = 0;
            ls_cnt[i] = 0; ls_frame[i] = 0; fs_last[i] = 0; fs_period[i] = 0;
            hs_prev[i] = 1'b1; vs_prev[i] = 1'b1;
        end
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                update(0, hs_m, vs_m, act_m, ls_m, fs_m);
                update(1, hs_s, vs_s, act_s, ls_s, fs_s);
                while (q_m.size() > 0 && q_m[0].cyc <= cyc) begin
                    e = q_m.pop_front();
                    compare(0, e);
                end
                while (q_s.size() > 0 && q_s[0].cyc <= cyc) begin
                    e = q_s.pop_front();
                    compare(1, e);
                end
            end
        end
    end

    // Stimulus and expectations
    initial begin
        int r2;
        rst_m = 1'b1;
        rst_s = 1'b1;
        ov_en = 1'b0;

        // Reset state (cycle 2, reset still asserted)
        push_m(2, S_X, 0);  push_m(2, S_Y, 0);  push_m(2, S_ACT, 1); push_m(2, S_FS, 0);
        push_m(2, S_LS, 0); push_m(2, S_HS, 1); push_m(2, S_VS, 1);  push_m(2, S_RGB, 0);
        push_m(2, S_FC, 0);
        // First cycle after release
        push_m(R, S_X, 0);  push_m(R, S_Y, 0);  push_m(R, S_ACT, 1); push_m(R, S_FS, 1);
        push_m(R, S_LS, 1); push_m(R, S_HS, 1); push_m(R, S_VS, 1);  push_m(R, S_RGB, 0);
        push_m(R, S_FC, 0);
        push_m(R + 1, S_X, 1); push_m(R + 1, S_FS, 0); push_m(R + 1, S_RGB, 6'b000011);
        // Active edge and blanking
        push_m(R + 639, S_ACT, 1);
        push_m(R + 640, S_ACT, 0); push_m(R + 640, S_RGB, 6'b000011);
        push_m(R + 641, S_RGB, 0);
        // Hsync window: low for x=656..751, one cycle delayed
        push_m(R + 656, S_X, 656); push_m(R + 656, S_HS, 1);
        push_m(R + 657, S_HS, 0);  push_m(R + 752, S_HS, 0);
        push_m(R + 753, S_HS, 1);  push_m(R + 753, S_HSW, 96);
        push_m(R + 799, S_X, 799); push_m(R + 799, S_Y, 0); push_m(R + 799, S_LS, 0);
        push_m(R + 800, S_X, 0);   push_m(R + 800, S_Y, 1); push_m(R + 800, S_LS, 1);
        push_m(R + 800, S_FS, 0);  push_m(R + 800, S_ACTL, 640);
        push_m(R + 1457, S_HSP, 800);

        // Small instance: 16-pixel lines, 11-line frames
        push_s(2, S_X, 0); push_s(2, S_HS, 1); push_s(2, S_VS, 1); push_s(2, S_RGB, 0);
        push_s(R, S_X, 0); push_s(R, S_Y, 0); push_s(R, S_FS, 1);
        push_s(R + 1, S_RGB, 6'b110110);
        push_s(R + 8, S_RGB, 6'b110110);
        push_s(R + 9, S_RGB, 0);
        push_s(R + 10, S_X, 10); push_s(R + 10, S_HS, 1);
        push_s(R + 11, S_HS, 0); push_s(R + 13, S_HS, 0);
        push_s(R + 14, S_HS, 1); push_s(R + 14, S_HSW, 3);
        push_s(R + 16, S_X, 0);  push_s(R + 16, S_Y, 1); push_s(R + 16, S_LS, 1);
        push_s(R + 87, S_ACT, 1); push_s(R + 96, S_ACT, 0);
        push_s(R + 112, S_VS, 1); push_s(R + 113, S_VS, 0); push_s(R + 144, S_VS, 0);
        push_s(R + 145, S_VS, 1); push_s(R + 145, S_VSW, 32);
        push_s(R + SF - 1, S_X, 15); push_s(R + SF - 1, S_Y, 10); push_s(R + SF - 1, S_FS, 0);
        push_s(R + SF, S_X, 0);  push_s(R + SF, S_Y, 0); push_s(R + SF, S_FS, 1);
        push_s(R + SF, S_FSP, SF); push_s(R + SF, S_LSF, 11); push_s(R + SF, S_FC, FC_EN);
        push_s(R + 255 * SF, S_FC, 255 * FC_EN);
        push_s(R + 256 * SF - 1, S_FC, 255 * FC_EN);
        push_s(R + 256 * SF, S_FC, 0); push_s(R + 256 * SF, S_FS, 1);

        wait_cyc(R);
        rst_m = 1'b0;
        rst_s = 1'b0;

        // Pixel mux: overlay at (100,50) and at blanked (700,50)
        wait_cyc(R + 2000);
        ov_en = 1'b1;
        push_m(R + 39301, S_RGB, 6'b000011);
        push_m(R + 40000, S_FC, 0);
        push_m(R + 40100, S_X, 100); push_m(R + 40100, S_Y, 50);
        push_m(R + 40100, S_RGB, 6'b000011);
        push_m(R + 40101, S_RGB, 6'b110110);
        push_m(R + 40102, S_RGB, 6'b000011);
        push_m(R + 40701, S_RGB, 0);

        // One-cycle reset at x=300, y=51
        wait_cyc(R + 41100);
        rst_m = 1'b1;
        r2 = R + 41101;
        push_m(R + 41100, S_X, 300); push_m(R + 41100, S_Y, 51); push_m(R + 41100, S_LS, 0);
        push_m(r2, S_X, 0); push_m(r2, S_Y, 0); push_m(r2, S_RGB, 0);
        push_m(r2, S_HS, 1); push_m(r2, S_FS, 1); push_m(r2, S_FC, 0);
        push_m(r2 + 1, S_X, 1); push_m(r2 + 1, S_RGB, 6'b000011);
        push_m(r2 + 656, S_HS, 1); push_m(r2 + 657, S_HS, 0);
        push_m(r2 + 753, S_HSW, 96);
        wait_cyc(r2);
        rst_m = 1'b0;

        // Drain scoreboard with a cycle budget
        while ((q_m.size() > 0 || q_s.size() > 0) && cyc < 46000) begin
            @(posedge clk);
        end
        while (q_m.size() > 0) begin
            checks++;
            $display("FAIL full.%s: never reached cycle %0d (required %0d)",
                     q_m[0].sel.name(), q_m[0].cyc, q_m[0].exp);
            void'(q_m.pop_front());
        end
        while (q_s.size() > 0) begin
            checks++;
            $display("FAIL small.%s: never reached cycle %0d (required %0d)",
                     q_s[0].sel.name(), q_s[0].cyc, q_s[0].exp);
            void'(q_s.pop_front());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
